// File: rtl/sdc_pkg.sv
// Shared types and constants for the SD-card SPI-mode bring-up sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sdc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DUMMY,
        ST_CMD0,
        ST_CMD8,
        ST_CMD55,
        ST_ACMD41,
        ST_CMD58,
        ST_READY,
        ST_ERR
    } sdc_init_state_t;

    // Command frames, byte 0 (start bits + index) in the low byte so it leaves first.
    localparam logic [47:0] SDC_CMD0  = 48'h95_00_00_00_00_40;
    localparam logic [47:0] SDC_CMD8  = 48'h87_AA_01_00_00_48;
    localparam logic [47:0] SDC_CMD55 = 48'h65_00_00_00_00_77;
    localparam logic [47:0] SDC_CMD41 = 48'h77_00_00_00_40_69;
    localparam logic [47:0] SDC_CMD58 = 48'hFD_00_00_00_00_7A;

    localparam logic [7:0]  R1_READY  = 8'h00;
    localparam logic [7:0]  R1_IDLE   = 8'h01;
    localparam logic [31:0] CMD8_ECHO = 32'h0000_01AA;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_CMD0      = 3'd1;
    localparam logic [2:0] ERR_CMD8_RESP = 3'd2;
    localparam logic [2:0] ERR_CMD8_ECHO = 3'd3;
    localparam logic [2:0] ERR_ACMD41    = 3'd4;
    localparam logic [2:0] ERR_CMD58     = 3'd5;
    localparam logic [2:0] ERR_NO_R1     = 3'd6;

    function automatic logic [79:0] frame80(input logic [47:0] f);
        return {32'h0, f};
    endfunction

endpackage

// File: rtl/sdc_r1_scan.sv
// Locates the R1 byte (first rx byte with bit7 clear) and the 4 bytes after it.
// Latency: combinational, 0 cycles.
// Backpressure: none; outputs follow ibuf/ilen directly.
// Ports: ibuf/ilen in (rx bytes, count); found/k/r1 out (R1 present, index, value);
//        trail out (bytes k+1..k+4, MSB first; zero when k>5 or no R1).
module sdc_r1_scan (
    input  logic [79:0] ibuf,
    input  logic [3:0]  ilen,
    output logic        found,
    output logic [3:0]  k,
    output logic [7:0]  r1,
    output logic [31:0] trail
);

    always_comb begin
        found = 1'b0;
        k     = 4'd0;
        r1    = 8'd0;
        trail = 32'd0;
        // Scan downward so the lowest matching index is the one that sticks.
        for (int i = 9; i >= 0; i--) begin
            if ((4'(i) < ilen) && !ibuf[8*i+7]) begin
                found = 1'b1;
                k     = 4'(i);
                r1    = ibuf[8*i +: 8];
            end
        end
        // Only k<=5 leaves four whole trailing bytes inside a 10-byte read.
        for (int i = 0; i <= 5; i++) begin
            if (found && (k == 4'(i))) begin
                trail = {ibuf[8*(i+1) +: 8], ibuf[8*(i+2) +: 8],
                         ibuf[8*(i+3) +: 8], ibuf[8*(i+4) +: 8]};
            end
        end
    end

endmodule

// File: rtl/sdc_init_seq.sv
// Drives the spi transaction engine through SD-card SPI-mode init (dummy clocks, CMD0/8/55/41/58).
// Latency: one gap cycle before each request, then one cycle after spi_valid to decide.
// Backpressure: spi_enable is held with stable obuf/olen/ilen/cs until spi_valid; start ignored while busy.
// Ports: clk/rst; start in, busy/ready/is_sdhc/err/err_code out;
//        spi_enable/spi_cclk/spi_cs/spi_obuf/spi_olen/spi_ilen out, spi_valid/spi_ibuf in.
module sdc_init_seq
    import sdc_pkg::*;
#(
    parameter int DUMMY_BYTES    = 10,
    parameter int CMD0_RETRIES   = 8,
    parameter int ACMD41_RETRIES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        ready,
    output logic        is_sdhc,
    output logic        err,
    output logic [2:0]  err_code,
    output logic        spi_enable,
    input  logic        spi_valid,
    output logic        spi_cclk,
    output logic        spi_cs,
    output logic [79:0] spi_obuf,
    output logic [3:0]  spi_olen,
    input  logic [79:0] spi_ibuf,
    output logic [3:0]  spi_ilen
);

    sdc_init_state_t state, state_nxt;
    logic        go, go_nxt;
    logic [9:0]  cmd0_cnt, cmd0_nxt, cmd0_inc;
    logic [9:0]  a41_cnt, a41_nxt, a41_inc;
    logic [2:0]  code_q, code_nxt, err_sel;
    logic        sdhc_q, sdhc_nxt;
    logic        found;
    logic [3:0]  k;
    logic [7:0]  r1;
    logic [31:0] trail;
    logic        done, long_bad, in_cmd;

    sdc_r1_scan u_scan (
        .ibuf  (spi_ibuf),
        .ilen  (spi_ilen),
        .found (found),
        .k     (k),
        .r1    (r1),
        .trail (trail)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            go       <= 1'b0;
            cmd0_cnt <= 10'd0;
            a41_cnt  <= 10'd0;
            code_q   <= ERR_NONE;
            sdhc_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            go       <= go_nxt;
            cmd0_cnt <= cmd0_nxt;
            a41_cnt  <= a41_nxt;
            code_q   <= code_nxt;
            sdhc_q   <= sdhc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd0_nxt  = cmd0_cnt;
        a41_nxt   = a41_cnt;
        code_nxt  = code_q;
        sdhc_nxt  = sdhc_q;
        err_sel   = ERR_NONE;
        cmd0_inc  = (cmd0_cnt == 10'h3FF) ? cmd0_cnt : cmd0_cnt + 10'd1;
        a41_inc   = (a41_cnt == 10'h3FF) ? a41_cnt : a41_cnt + 10'd1;
        in_cmd    = state inside {ST_DUMMY, ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD58};
        done      = go && spi_valid;
        long_bad  = !found || (k > 4'd5);
        // go is low for the first cycle in a state (or after a retry), which both
        // separates requests and pulls cs low between commands.
        go_nxt    = in_cmd && !done;

        case (state)
            ST_IDLE, ST_READY, ST_ERR: begin
                if (start) begin
                    state_nxt = ST_DUMMY;
                    cmd0_nxt  = 10'd0;
                    a41_nxt   = 10'd0;
                    code_nxt  = ERR_NONE;
                    sdhc_nxt  = 1'b0;
                end
            end
            ST_DUMMY: begin
                if (done) state_nxt = ST_CMD0;
            end
            ST_CMD0: begin
                if (done) begin
                    if (found && (r1 == R1_IDLE)) begin
                        state_nxt = ST_CMD8;
                    end else begin
                        // A missing R1 is just another failed attempt here.
                        cmd0_nxt = cmd0_inc;
                        if (int'(cmd0_inc) >= CMD0_RETRIES) err_sel = ERR_CMD0;
                    end
                end
            end
            ST_CMD8: begin
                if (done) begin
                    if (long_bad)                err_sel   = ERR_NO_R1;
                    else if (r1 != R1_IDLE)      err_sel   = ERR_CMD8_RESP;
                    else if (trail != CMD8_ECHO) err_sel   = ERR_CMD8_ECHO;
                    else                         state_nxt = ST_CMD55;
                end
            end
            ST_CMD55: begin
                if (done) begin
                    if (!found)                                  err_sel   = ERR_NO_R1;
                    else if ((r1 == R1_READY) || (r1 == R1_IDLE)) state_nxt = ST_ACMD41;
                    else                                         err_sel   = ERR_ACMD41;
                end
            end
            ST_ACMD41: begin
                if (done) begin
                    if (!found) begin
                        err_sel = ERR_NO_R1;
                    end else if (r1 == R1_READY) begin
                        state_nxt = ST_CMD58;
                    end else if (r1 == R1_IDLE) begin
                        a41_nxt = a41_inc;
                        if (int'(a41_inc) >= ACMD41_RETRIES) err_sel   = ERR_ACMD41;
                        else                                 state_nxt = ST_CMD55;
                    end else begin
                        err_sel = ERR_ACMD41;
                    end
                end
            end
            ST_CMD58: begin
                if (done) begin
                    if (long_bad)            err_sel = ERR_NO_R1;
                    else if (r1 != R1_READY) err_sel = ERR_CMD58;
                    else begin
                        sdhc_nxt  = trail[30];
                        state_nxt = ST_READY;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (err_sel != ERR_NONE) begin
            state_nxt = ST_ERR;
            code_nxt  = err_sel;
        end
    end

    always_comb begin
        busy       = in_cmd;
        ready      = (state == ST_READY);
        err        = (state == ST_ERR);
        err_code   = code_q;
        is_sdhc    = sdhc_q;
        spi_enable = go;
        spi_cclk   = in_cmd;
        spi_cs     = go && (state != ST_DUMMY);
        spi_obuf   = 80'd0;
        spi_olen   = 4'd0;
        spi_ilen   = 4'd0;
        case (state)
            ST_DUMMY: begin
                for (int i = 0; i < 10; i++) begin
                    if (i < DUMMY_BYTES) spi_obuf[8*i +: 8] = 8'hFF;
                end
                spi_olen = 4'(DUMMY_BYTES);
            end
            ST_CMD0: begin
                spi_obuf = frame80(SDC_CMD0);
                spi_olen = 4'd6;
                spi_ilen = 4'd8;
            end
            ST_CMD8: begin
                spi_obuf = frame80(SDC_CMD8);
                spi_olen = 4'd6;
                spi_ilen = 4'd10;
            end
            ST_CMD55: begin
                spi_obuf = frame80(SDC_CMD55);
                spi_olen = 4'd6;
                spi_ilen = 4'd8;
            end
            ST_ACMD41: begin
                spi_obuf = frame80(SDC_CMD41);
                spi_olen = 4'd6;
                spi_ilen = 4'd8;
            end
            ST_CMD58: begin
                spi_obuf = frame80(SDC_CMD58);
                spi_olen = 4'd6;
                spi_ilen = 4'd10;
            end
            default: ;
        endcase
    end

endmodule
